imem_responder: RTL

//   Instruction-memory responder: the memory end of the fetch interface. Accepts a fetch address

---
 rtl/imem_pkg.sv | 12 +
 rtl/imem_array.sv | 61 ++++++
 rtl/imem_responder.sv | 104 ++++++++++
 3 files changed

// File: rtl/imem_pkg.sv
// Shared types and constants for the instruction-memory responder.
package imem_pkg;

  typedef enum logic [0:0] {
    StClear,
    StServe
  } imem_state_e;

  // Fill word written during CLEAR and returned for unimplemented addresses.
  localparam logic [15:0] NOP_WORD = 16'h0000;

endpackage

// File: rtl/imem_array.sv
// DEPTH x DATA_W storage with one write port and one registered read port.
// A read and a write to the same address in one cycle return the new data.
module imem_array
  import imem_pkg::*;
#(
  parameter int unsigned       ADDR_W = 4,
  parameter int unsigned       DATA_W = 16,
  parameter int unsigned       DEPTH  = 16,
  parameter logic [DATA_W-1:0] NOP    = DATA_W'(NOP_WORD)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  localparam int unsigned       IdxW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0]   DepthA = (ADDR_W + 1)'(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              rd_hit;
  logic              bypass;

  assign rd_hit = ({1'b0, raddr} < DepthA);
  // Caller only raises we for in-range addresses, so a match implies a real write.
  assign bypass = we && (waddr == raddr);

  // Storage write; contents are initialised by the owner, not by reset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr[IdxW-1:0]] <= wdata;
    end
  end

  // Read data selection: bypass first, then array, else fill word.
  always_comb begin
    rdata_d = NOP;
    if (bypass) begin
      rdata_d = wdata;
    end else if (rd_hit) begin
      rdata_d = mem_q[raddr[IdxW-1:0]];
    end
  end

  // Read register holds its value when no read is issued.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rdata_q <= NOP;
    end else if (re) begin
      rdata_q <= rdata_d;
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/imem_responder.sv
// Instruction-memory responder: clears the array after reset, then serves
// single-cycle-latency fetches and accepts program-load writes.
module imem_responder
  import imem_pkg::*;
#(
  parameter int unsigned       ADDR_W = 4,
  parameter int unsigned       DATA_W = 16,
  parameter int unsigned       DEPTH  = 16,
  parameter logic [DATA_W-1:0] NOP    = DATA_W'(NOP_WORD)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              fetch_req,
  input  logic [ADDR_W-1:0] address_to_memory,
  input  logic              load_en,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [DATA_W-1:0] load_data,
  output logic [DATA_W-1:0] data_from_memory,
  output logic              data_valid,
  output logic              ready
);

  localparam int unsigned     CntW    = $clog2(DEPTH) + 1;
  localparam logic [CntW-1:0] LastIdx = CntW'(DEPTH - 1);
  localparam logic [ADDR_W:0] DepthA  = (ADDR_W + 1)'(DEPTH);

  imem_state_e       state_q, state_d;
  logic [CntW-1:0]   clr_cnt_q, clr_cnt_d;
  logic              ready_q;
  logic              valid_q;

  logic              serve;
  logic              fetch_en;
  logic              load_ok;
  logic              arr_we;
  logic [ADDR_W-1:0] arr_waddr;
  logic [DATA_W-1:0] arr_wdata;

  assign serve    = (state_q == StServe);
  assign fetch_en = serve && fetch_req;
  // Out-of-range loads are silently dropped.
  assign load_ok  = serve && load_en && ({1'b0, load_addr} < DepthA);

  // Next state, clear counter and write-port mux.
  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    arr_we    = 1'b0;
    arr_waddr = load_addr;
    arr_wdata = load_data;
    unique case (state_q)
      StClear: begin
        arr_we    = 1'b1;
        arr_waddr = ADDR_W'(clr_cnt_q);
        arr_wdata = NOP;
        clr_cnt_d = clr_cnt_q + CntW'(1);
        if (clr_cnt_q == LastIdx) begin
          state_d = StServe;
        end
      end
      StServe: begin
        arr_we = load_ok;
      end
      default: begin
        state_d = StClear;
      end
    endcase
  end

  // State, counter, ready and valid registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= StClear;
      clr_cnt_q <= '0;
      ready_q   <= 1'b0;
      valid_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
      ready_q   <= (state_d == StServe);
      valid_q   <= fetch_en;
    end
  end

  imem_array #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .NOP    (NOP)
  ) u_array (
    .clk   (clk),
    .reset (reset),
    .we    (arr_we),
    .waddr (arr_waddr),
    .wdata (arr_wdata),
    .re    (fetch_en),
    .raddr (address_to_memory),
    .rdata (data_from_memory)
  );

  assign data_valid = valid_q;
  assign ready      = ready_q;

endmodule
